message_buffer_ctrl: RTL
========================

// Module: message_buffer_ctrl
// PURPOSE
//  Sequences the character stream from the keyboard/character path (New strobe + 7-bit Char) into a
//  message buffer, interpreting edit codes: backspace, enter and escape.
//  Arbitrates the single-port buffer between the writer and the POV display scanner (read requester).
//  Sits between the character path and the LED column renderer.
// PARAMETERS
//  DEPTH  32  message buffer entries (characters); power of two
//  AW     5   address width, log2(DEPTH)
//  CW     7   character width (ASCII)
// PORTS
//  Clock    in   1     system clock, all logic rising edge
//  Reset    in   1     asynchronous, active-low reset
//  New      in   1     one-cycle strobe: Char valid
//  Char     in   CW    ASCII code from character path
//  RdReq    in   1     display read request, level; held until RdValid
//  RdAddr   in   AW    display read address, stable while RdReq high
//  RdData   out  CW    read data, valid when RdValid=1
//  RdValid  out  1     one-cycle read-complete pulse
//  MsgLen   out  AW+1  committed message length (0..DEPTH)
//  Commit   out  1     one-cycle pulse when enter commits the message
//  Busy     out  1     high in WRITE or CLEAR state
//  Overflow out  1     sticky: printable char dropped because buffer full; cleared by escape/reset
// BEHAVIOUR
//  Reset (Reset=0, async): state=CLEAR, ClrPtr=0, WrPtr=0, MsgLen=0, RdData=0, RdValid=0, Commit=0,
//   Overflow=0, Busy=1. The buffer is filled with spaces after reset release.
//  States:
//   IDLE   Busy=0. New=1 -> latch Char, go to WRITE (New beats RdReq in the same cycle).
//          Else, RdReq=1 -> grant read: RdData<=buf[RdAddr] (0x20 if RdAddr>=MsgLen), RdValid=1 next
//          cycle; stay IDLE.
//   WRITE  One cycle, Busy=1, no read grant. Decode the latched char:
//          0x20..0x7E: if WrPtr<DEPTH, write buf[WrPtr] and WrPtr+1; else drop and set Overflow=1.
//          0x08: if WrPtr>0, WrPtr-1 and write buf[WrPtr-1]=0x20; at 0, no change.
//          0x0D: MsgLen<=WrPtr, Commit=1 for one cycle, WrPtr unchanged (editing continues/appends).
//          0x1B: WrPtr=0, MsgLen=0, Overflow=0, ClrPtr=0, go to CLEAR.
//          Any other code: ignored.
//          Exit to IDLE unless going to CLEAR.
//   CLEAR  Busy=1. Write buf[ClrPtr]=0x20, ClrPtr+1 each cycle. After DEPTH cycles (ClrPtr wraps to
//          0), go to IDLE. New is dropped silently. RdReq stalls, then is served in IDLE.
//  Read latency: 1 cycle from the grant edge.
//   A request arriving during WRITE or CLEAR is served on the first IDLE cycle with New=0.
//   Back-to-back: RdReq held high after RdValid yields one grant per IDLE cycle.
//   The requester drops RdReq in the cycle RdValid is seen to avoid a duplicate read.
//  Write pointer width is AW+1, so WrPtr==DEPTH is representable. No wrap-around: full is a hard stop.
//  MsgLen changes only on enter, escape or reset. Display reads past MsgLen return space, so the visible
//   message is the last committed one.
//  Back-to-back New strobes one cycle apart are not allowed upstream (min 2-cycle spacing).
//   If one arrives in WRITE, it is dropped.
// TESTING
//  1 Reset, wait 32 cycles -> Busy falls exactly 32 cycles after release; any read returns 0x20.
//  2 Type 'H','I',0x0D -> Commit pulse once, MsgLen=2; read addr0=0x48, addr1=0x49, addr2=0x20,
//    each with RdValid 1 cycle after grant.
//  3 'A','B',0x08,'C',0x0D -> MsgLen=2, buf[1]=0x43. 0x08 at WrPtr=0 -> no change, no underflow.
//  4 33 printable chars then 0x0D -> MsgLen=32, Overflow=1. Then 0x1B -> Overflow=0, MsgLen=0,
//    Busy high 33 cycles (WRITE+32 CLEAR).
//  5 New and RdReq same cycle -> write done first, RdValid 2 cycles later. RdReq during CLEAR ->
//    RdValid 1 cycle after CLEAR exits.
//  6 Assert Reset mid-CLEAR and mid-WRITE -> outputs at reset values immediately; full clear restarts.

Source files
------------

// File: rtl/message_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : message_buffer_ctrl
//  Edit-code aware writer for the single-port message buffer, arbitrated
//  against POV display read requests.
//  Rev    : 1.0  initial release
// ============================================================================
module message_buffer_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 7
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          New,
    input  logic [CW-1:0] Char,
    input  logic          RdReq,
    input  logic [AW-1:0] RdAddr,
    output logic [CW-1:0] RdData,
    output logic          RdValid,
    output logic [AW:0]   MsgLen,
    output logic          Commit,
    output logic          Busy,
    output logic          Overflow
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CH_SPACE = CW'(8'h20);
    localparam logic [CW-1:0] CH_TILDE = CW'(8'h7E);
    localparam logic [CW-1:0] CH_BS    = CW'(8'h08);
    localparam logic [CW-1:0] CH_CR    = CW'(8'h0D);
    localparam logic [CW-1:0] CH_ESC   = CW'(8'h1B);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH-1);

    logic [CW-1:0] mem [DEPTH];

    state_t        state, state_nx;
    logic [CW-1:0] char_q;
    logic [AW:0]   wr_ptr, wr_ptr_nx, wr_ptr_dec;
    logic [AW-1:0] clr_ptr, clr_ptr_nx;
    logic [AW:0]   msg_len_nx;
    logic          overflow_nx;
    logic          commit_nx;
    logic          rd_grant;
    logic          latch_char;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;

    assign wr_ptr_dec = wr_ptr - PTR_ONE;
    assign Busy       = (state != ST_IDLE);

    always_comb begin
        state_nx    = state;
        wr_ptr_nx   = wr_ptr;
        clr_ptr_nx  = clr_ptr;
        msg_len_nx  = MsgLen;
        overflow_nx = Overflow;
        commit_nx   = 1'b0;
        rd_grant    = 1'b0;
        latch_char  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = wr_ptr[AW-1:0];
        mem_wdata   = CH_SPACE;
        case (state)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = clr_ptr;
                clr_ptr_nx = clr_ptr + AW'(1);
                if (clr_ptr == CLR_LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A character strobe wins over a display read in the same cycle
                if (New) begin
                    latch_char = 1'b1;
                    state_nx   = ST_WRITE;
                end else if (RdReq) begin
                    rd_grant = 1'b1;
                end
            end
            ST_WRITE: begin
                state_nx = ST_IDLE;
                if ((char_q >= CH_SPACE) && (char_q <= CH_TILDE)) begin
                    if (wr_ptr < PTR_FULL) begin
                        mem_we    = 1'b1;
                        mem_wdata = char_q;
                        wr_ptr_nx = wr_ptr + PTR_ONE;
                    end else begin
                        overflow_nx = 1'b1;
                    end
                end else begin
                    case (char_q)
                        CH_BS: begin
                            if (wr_ptr != '0) begin
                                wr_ptr_nx = wr_ptr_dec;
                                mem_we    = 1'b1;
                                mem_addr  = wr_ptr_dec[AW-1:0];
                            end
                        end
                        CH_CR: begin
                            msg_len_nx = wr_ptr;
                            commit_nx  = 1'b1;
                        end
                        CH_ESC: begin
                            wr_ptr_nx   = '0;
                            msg_len_nx  = '0;
                            overflow_nx = 1'b0;
                            clr_ptr_nx  = '0;
                            state_nx    = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_CLEAR;
            char_q   <= '0;
            wr_ptr   <= '0;
            clr_ptr  <= '0;
            MsgLen   <= '0;
            Overflow <= 1'b0;
            Commit   <= 1'b0;
            RdValid  <= 1'b0;
            RdData   <= '0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr_nx;
            clr_ptr  <= clr_ptr_nx;
            MsgLen   <= msg_len_nx;
            Overflow <= overflow_nx;
            Commit   <= commit_nx;
            RdValid  <= rd_grant;
            if (latch_char) begin
                char_q <= Char;
            end
            // Anything beyond the committed length shows as blank on the display
            if (rd_grant) begin
                RdData <= ({1'b0, RdAddr} >= MsgLen) ? CH_SPACE : mem[RdAddr];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule
`default_nettype wire
